// File: rtl/instr_cache_param.sv
// Parametrised direct-mapped instruction cache with whole-line refill and flush.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt statistics outputs.
module instr_cache_param #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic        flush,
    input  logic        cached_instr_req,
    input  logic [31:0] cached_instr_adr,
    output logic        cached_instr_gnt,
    output logic        cached_instr_rvalid,
    output logic [31:0] cached_instr_read,
`ifdef ICACHE_STATS_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    output logic        instr_req,
    output logic [31:0] instr_adr,
    input  logic        instr_gnt,
    input  logic        instr_rvalid,
    input  logic [31:0] instr_read
);
    localparam int OFF   = $clog2(WORDS_PER_LINE);
    localparam int IDX   = $clog2(LINES);
    localparam int TAGW  = 32 - 2 - OFF - IDX;
    localparam int DEPTH = LINES * WORDS_PER_LINE;
    localparam logic [OFF-1:0] LAST_WORD = OFF'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [LINES-1:0] r_valid;
    logic [TAGW-1:0]  r_tag_mem [LINES];
    logic [31:0]      r_data_mem [DEPTH];
    logic [TAGW-1:0]  r_tag;
    logic [IDX-1:0]   r_idx;
    logic [OFF-1:0]   r_cnt;
    logic             r_flush_pend;
    logic             r_rvalid;
    logic [31:0]      r_read;
    logic             r_instr_req;

    logic [OFF-1:0]   w_off;
    logic [IDX-1:0]   w_idx;
    logic [TAGW-1:0]  w_tag;
    logic             w_hit;
    logic             w_last;
    logic             w_grant;
    logic             w_miss;
    logic             w_fill;
    logic             w_fill_done;
    logic             w_unused_adr;

    assign w_off        = cached_instr_adr[2+OFF-1:2];
    assign w_idx        = cached_instr_adr[2+OFF+IDX-1:2+OFF];
    assign w_tag        = cached_instr_adr[31:2+OFF+IDX];
    assign w_unused_adr = ^cached_instr_adr[1:0];
    assign w_hit        = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);
    assign w_last       = (r_cnt == LAST_WORD);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_miss       = 1'b0;
        w_fill       = 1'b0;
        w_fill_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cached_instr_req && !res && !flush) begin
                    if (w_hit) begin
                        w_grant = 1'b1;
                    end else begin
                        w_miss       = 1'b1;
                        w_state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (instr_gnt) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (instr_rvalid) begin
                    w_fill = 1'b1;
                    if (w_last) begin
                        w_fill_done  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_REQ;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_tag        <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_rvalid     <= 1'b0;
            r_read       <= '0;
            r_instr_req  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rvalid    <= w_grant;
            r_instr_req <= (w_state_next == S_REQ);
            if (w_grant) r_read <= r_data_mem[{w_idx, w_off}];
            if (w_miss) begin
                r_tag          <= w_tag;
                r_idx          <= w_idx;
                r_cnt          <= '0;
                r_valid[w_idx] <= 1'b0;
            end
            if (w_fill && !w_last) r_cnt <= r_cnt + 1'b1;
            if (r_state == S_IDLE) begin
                if (flush) r_valid <= '0;
            end else begin
                if (flush) r_flush_pend <= 1'b1;
                // A flush seen at any point of the refill keeps the new line invalid.
                if (w_fill_done) begin
                    if (r_flush_pend || flush) r_valid <= '0;
                    else                       r_valid[r_idx] <= 1'b1;
                    r_flush_pend <= 1'b0;
                end
            end
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (!res && w_fill) r_data_mem[{r_idx, r_cnt}] <= instr_read;
        if (!res && w_fill_done) r_tag_mem[r_idx] <= r_tag;
    end

    assign cached_instr_gnt    = w_grant;
    assign cached_instr_rvalid = r_rvalid;
    assign cached_instr_read   = r_read;
    assign instr_req           = r_instr_req;
    assign instr_adr           = {r_tag, r_idx, r_cnt, 2'b00};

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (res) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_grant) r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_miss)  r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: doc/instr_cache_param.md
# instr_cache_param

Parametrised direct-mapped instruction cache between the `proc` fetch port and the SoC instruction memory port. It is the successor to the fixed-geometry `instr_cache`, with configurable line count and line length, whole-line refill, and a software-triggered flush. Both sides use the same req/gnt/rvalid handshake, so the block drops into `system` in place of `instr_cache`.

## Interface
- `LINES`, 16: number of cache lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, ≥2.
- `clk` in 1: clock.
- `res` in 1: reset; one clock, synchronous, active-high.
- `flush` in 1: one-cycle pulse that invalidates all lines.
- `cached_instr_req` in 1: CPU fetch request; held with address until `cached_instr_gnt`.
- `cached_instr_adr` in 32: CPU byte address; bits [1:0] are ignored.
- `cached_instr_gnt` out 1: request accepted (hit).
- `cached_instr_rvalid` out 1: `cached_instr_read` valid.
- `cached_instr_read` out 32: instruction word.
- `instr_req` out 1: memory request.
- `instr_adr` out 32: memory word-aligned byte address.
- `instr_gnt` in 1: memory accepted request.
- `instr_rvalid` in 1: memory data valid; arrives ≥1 cycle after `instr_gnt`.
- `instr_read` in 32: memory data.

## Operation
- Address split: OFF = log2(WORDS_PER_LINE), IDX = log2(LINES).
  - word offset = adr[2+OFF-1:2]
  - index = adr[2+OFF+IDX-1:2+OFF]
  - tag = adr[31:2+OFF+IDX]
- Storage per line: valid bit, tag, and WORDS_PER_LINE data words.
- Hit = `valid[index]` and `tag_mem[index] == tag`.
- FSM states: IDLE, REQ, WAIT.
  - **IDLE:** `cached_instr_gnt = cached_instr_req & hit & ~res & ~flush`, combinational.
    - On a grant, register the data word and assert `cached_instr_rvalid` next cycle.
    - On `req & ~hit` (and no flush): latch tag and index, clear `valid[index]`, word counter = 0, go to REQ.
  - **REQ:** drive `instr_req` = 1 and `instr_adr` = {tag, index, cnt, 2'b00}. On `instr_gnt`, drop `instr_req` and go to WAIT.
  - **WAIT:** on `instr_rvalid`, write `instr_read` into word `cnt`.
    - If `cnt` = WORDS_PER_LINE−1: write tag, set valid (unless a flush is pending), go to IDLE.
    - Otherwise: `cnt`++, go to REQ.
- Only one memory request is outstanding at a time. Refill order is word 0 upward.
- After a refill the CPU request is still held, so it hits in IDLE. Miss-to-rvalid latency is therefore 2·WORDS_PER_LINE + 2 cycles with zero-wait memory.
- Flush:
  - In IDLE: all valid bits clear at the next edge. No grant is given in the flush cycle.
  - In REQ/WAIT: set `flush_pend`. The refill completes, but the line is not validated. On return to IDLE, all valid bits clear and `flush_pend` clears.
- `instr_rvalid` in IDLE (stray response after a reset) is ignored.

## Timing
- Reset values: `cached_instr_gnt` 0, `cached_instr_rvalid` 0, `cached_instr_read` 0, `instr_req` 0, `instr_adr` 0. All valid bits 0, state IDLE, `cnt` 0, `flush_pend` 0.
- Reset mid-refill abandons the refill. The partial line stays invalid.
- Hit: `req` and `gnt` in cycle N; `rvalid` and `read` in N+1 for exactly one cycle. Back-to-back hits give one word per cycle.
- `cached_instr_read` holds its last value while `rvalid` = 0.
- `instr_req` is registered and stays high until the cycle `instr_gnt` is sampled high. `instr_adr` is stable while `instr_req` = 1.
- Flush in the same cycle as a hitting request: the flush wins and there is no grant. The request then misses the following cycle.
- Conflict miss (same index, different tag): the old line is overwritten.
- A request to the line being refilled is not granted until the refill completes.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Adds outputs `hit_cnt` (out 32) and `miss_cnt` (out 32).
  - `hit_cnt` increments on every `cached_instr_gnt`. `miss_cnt` increments on every IDLE→REQ transition.
  - Both wrap modulo 2^32, clear only on `res`, and are unaffected by `flush`.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Defaults, zero-wait memory; after reset, fetch 0x100 → memory addresses 0x100, 0x104, 0x108, 0x10C requested in order, `gnt` at cycle 10, `rvalid` at cycle 11 with mem[0x100].
- After the above, fetch 0x104, 0x108, 0x10C back-to-back → 3 grants in 3 cycles, no `instr_req`, correct data.
- Fetch 0x100 then 0x200 (same index 0, different tag) then 0x100 → three refills; the third returns mem[0x100].
- `flush` pulse while in WAIT on word 1 of a 0x300 refill → refill finishes; a re-fetch of 0x300 triggers a new 4-word refill.
- Assert `res` during REQ of word 2; memory later returns stray `rvalid` → ignored; fetch of the same line fully refills from word 0.
- With `ICACHE_STATS_EN`: 1 miss followed by 3 hits → `miss_cnt` = 1, `hit_cnt` = 4 (includes the post-refill grant).
